// File: rtl/dot_product_arbiter.sv
// dot_product_arbiter
//   Shares one non-pipelined FP16 3-element dot-product unit between NUM_REQ
//   requesters with round-robin arbitration. The winner's operands are latched
//   and held on the datapath for the whole operation, the datapath is started
//   with a one-cycle enable, and the result is returned tagged with the
//   requester index. A watchdog aborts an operation whose valid never arrives.
//
// Ports
//   clk, rst_n          clock (posedge) and asynchronous active-low reset
//   req                 per-requester level request, held until granted
//   req_vec_a/_b        per-requester operands, slice i = [48*i+47:48*i]
//   gnt                 one-hot grant, combinational, only in IDLE
//   rsp_valid           one-cycle result strobe
//   rsp_id/_data/_err   result tag, FP16 result (0 on error), timeout flag
//   busy                high whenever the arbiter is not IDLE
//   dp_en               one-cycle datapath start
//   dp_vec_a/_b         operands held stable for the datapath
//   dp_product/dp_valid datapath result and its valid strobe
module dot_product_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ),
  parameter int TIMEOUT = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_REQ-1:0]    req,
  input  logic [NUM_REQ*48-1:0] req_vec_a,
  input  logic [NUM_REQ*48-1:0] req_vec_b,
  output logic [NUM_REQ-1:0]    gnt,
  output logic                  rsp_valid,
  output logic [ID_W-1:0]       rsp_id,
  output logic [15:0]           rsp_data,
  output logic                  rsp_err,
  output logic                  busy,
  output logic                  dp_en,
  output logic [47:0]           dp_vec_a,
  output logic [47:0]           dp_vec_b,
  input  logic [15:0]           dp_product,
  input  logic                  dp_valid
);

  localparam int CNT_W = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t             state_r;
  state_t             state_nxt_s;
  logic [ID_W-1:0]    ptr_r;
  logic [ID_W-1:0]    winner_s;
  logic [ID_W-1:0]    idx_s;
  logic               hit_s;
  logic               found_s;
  logic               grant_s;
  logic [NUM_REQ-1:0] gnt_s;
  logic [CNT_W-1:0]   cnt_r;
  logic               timeout_s;
  logic [47:0]        dp_vec_a_r;
  logic [47:0]        dp_vec_b_r;
  logic [ID_W-1:0]    rsp_id_r;
  logic [15:0]        rsp_data_r;
  logic               rsp_err_r;
  logic               rsp_valid_r;
  logic               dp_en_r;
  logic               busy_r;

  // (base + off) mod NUM_REQ; both operands are below NUM_REQ, so one
  // conditional subtraction is enough.
  function automatic logic [ID_W-1:0] wrap_inc(input logic [ID_W-1:0] base,
                                               input logic [ID_W:0]   off);
    logic [ID_W+1:0] sum;
    sum = {2'b00, base} + {1'b0, off};
    if (sum >= (ID_W+2)'(NUM_REQ)) begin
      sum = sum - (ID_W+2)'(NUM_REQ);
    end else begin
      sum = sum;
    end
    return sum[ID_W-1:0];
  endfunction

  // Round-robin search: first set request at or after ptr_r, with wrap-around
  always_comb begin
    found_s  = 1'b0;
    winner_s = '0;
    idx_s    = '0;
    hit_s    = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx_s    = wrap_inc(ptr_r, (ID_W+1)'(i));
      hit_s    = !found_s && req[idx_s];
      winner_s = hit_s ? idx_s : winner_s;
      found_s  = found_s | hit_s;
    end
  end

  assign grant_s   = (state_r == IDLE) && found_s;
  assign timeout_s = (cnt_r == CNT_LAST);

  // One-hot grant decode, only while IDLE
  always_comb begin
    gnt_s = '0;
    if (grant_s) begin
      gnt_s[winner_s] = 1'b1;
    end else begin
      gnt_s = '0;
    end
  end

  // Next-state logic; a valid on the timeout cycle still counts as success
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (found_s) begin
          state_nxt_s = ISSUE;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      ISSUE: state_nxt_s = WAIT;
      WAIT: begin
        if (dp_valid || timeout_s) begin
          state_nxt_s = RESP;
        end else begin
          state_nxt_s = WAIT;
        end
      end
      RESP:    state_nxt_s = IDLE;
      default: state_nxt_s = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Status strobes registered from the next state so they align with it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dp_en_r     <= 1'b0;
      busy_r      <= 1'b0;
      rsp_valid_r <= 1'b0;
    end else begin
      dp_en_r     <= (state_nxt_s == ISSUE);
      busy_r      <= (state_nxt_s != IDLE);
      rsp_valid_r <= (state_nxt_s == RESP);
    end
  end

  // Capture winner operands, tag and next round-robin start on the grant edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dp_vec_a_r <= 48'h0;
      dp_vec_b_r <= 48'h0;
      rsp_id_r   <= '0;
      ptr_r      <= '0;
    end else if (grant_s) begin
      dp_vec_a_r <= req_vec_a[48*winner_s +: 48];
      dp_vec_b_r <= req_vec_b[48*winner_s +: 48];
      rsp_id_r   <= winner_s;
      ptr_r      <= wrap_inc(winner_s, (ID_W+1)'(1));
    end
  end

  // Watchdog: cleared on issue, counts every WAIT cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= '0;
    end else if (state_r == ISSUE) begin
      cnt_r <= '0;
    end else if (state_r == WAIT) begin
      cnt_r <= cnt_r + CNT_W'(1);
    end
  end

  // Result capture; dp_valid outside WAIT is ignored
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_data_r <= 16'h0000;
      rsp_err_r  <= 1'b0;
    end else if (state_r == WAIT) begin
      if (dp_valid) begin
        rsp_data_r <= dp_product;
        rsp_err_r  <= 1'b0;
      end else if (timeout_s) begin
        rsp_data_r <= 16'h0000;
        rsp_err_r  <= 1'b1;
      end
    end
  end

  assign gnt       = gnt_s;
  assign rsp_valid = rsp_valid_r;
  assign rsp_id    = rsp_id_r;
  assign rsp_data  = rsp_data_r;
  assign rsp_err   = rsp_err_r;
  assign busy      = busy_r;
  assign dp_en     = dp_en_r;
  assign dp_vec_a  = dp_vec_a_r;
  assign dp_vec_b  = dp_vec_b_r;

endmodule
